// File: rtl/me_pkg.sv
// me_pkg: shared constants and state type for the modexp result collector.
package me_pkg;
    localparam int K = 128;
    localparam int N = 16;
    localparam int CNT_W = 5;
    localparam int RSA_W = K * N;
    typedef enum logic {IDLE, COLLECT} state_e;
endpackage

// File: rtl/me_result_collector_if.sv
// me_result_collector_if: word-serial input and wide valid/ready output of the collector.
interface me_result_collector_if;
    import me_pkg::*;
    logic             clr;
    logic [K-1:0]     me_result;
    logic             me_valid;
    logic [RSA_W-1:0] rsa_result;
    logic             rsa_valid;
    logic             rsa_ready;
    logic             busy;
    logic             err_overflow;
`ifdef ME_COLLECT_CNT_EN
    logic [31:0]      result_cnt;
`endif
    modport slave (
        input  clr, me_result, me_valid, rsa_ready,
        output rsa_result, rsa_valid, busy, err_overflow
`ifdef ME_COLLECT_CNT_EN
        , output result_cnt
`endif
    );
    modport master (
        output clr, me_result, me_valid, rsa_ready,
        input  rsa_result, rsa_valid, busy, err_overflow
`ifdef ME_COLLECT_CNT_EN
        , input result_cnt
`endif
    );
endinterface

// File: rtl/me_word_deserializer.sv
// me_word_deserializer: right-loading shift buffer with word counter; done_o pulses the cycle after the last word lands.
module me_word_deserializer
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [K-1:0]     word_i,
    input  logic             valid_i,
    output logic [RSA_W-1:0] data_o,
    output logic             done_o,
    output logic             busy_o
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RSA_W-1:0] sh_q, sh_d;
    logic             done_q, done_d;
    logic             cap, last;

    always_comb begin
        cap     = valid_i & ~clr_i;
        last    = cap & (cnt_q == CNT_W'(N - 1));
        cnt_d   = (clr_i | last) ? '0 : cap ? cnt_q + 1'b1 : cnt_q;
        state_d = (clr_i | last) ? IDLE : cap ? COLLECT : state_q;
        sh_d    = cap ? {word_i, sh_q[RSA_W-1:K]} : sh_q;
        done_d  = last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
        end
    end

    assign data_o = sh_q;
    assign done_o = done_q;
    assign busy_o = (state_q == COLLECT);
endmodule

// File: rtl/me_result_collector.sv
// me_result_collector: reassembles N K-bit modexp words into a held K*N-bit result with valid/ready and overflow flag.
// Optional ME_COLLECT_CNT_EN adds result_cnt, counting results delivered to the consumer.
module me_result_collector
    import me_pkg::*;
(
    input logic           clk,
    input logic           rst,
    me_result_collector_if.slave bus
);
    logic [RSA_W-1:0] des_data, res_q, res_d;
    logic             des_done, vld_q, vld_d, err_q, err_d, take, load;

    me_word_deserializer u_des (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.clr),
        .word_i  (bus.me_result),
        .valid_i (bus.me_valid),
        .data_o  (des_data),
        .done_o  (des_done),
        .busy_o  (bus.busy)
    );

    // A completion is only dropped when the held result is neither empty nor being taken.
    always_comb begin
        take  = vld_q & bus.rsa_ready;
        load  = des_done & (~vld_q | bus.rsa_ready);
        res_d = load ? des_data : res_q;
        vld_d = load | (vld_q & ~take);
        err_d = bus.clr ? 1'b0 : err_q | (des_done & ~load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

`ifdef ME_COLLECT_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_q + {31'b0, take};
    end
    assign bus.result_cnt = cnt_q;
`endif

    assign bus.rsa_result   = res_q;
    assign bus.rsa_valid    = vld_q;
    assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_me_result_collector.sv
// tb_me_result_collector: directed and random stimulus checked against a word-queue reference model.
module tb_me_result_collector;
    import me_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    me_result_collector_if bus ();
    me_result_collector dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [K-1:0]     q[$];
    bit               pend, m_valid, m_err;
    logic [RSA_W-1:0] pend_val, m_result;
    logic [31:0]      m_cnt;

    task automatic model_reset();
        q.delete();
        pend = 0; m_valid = 0; m_err = 0;
        pend_val = '0; m_result = '0; m_cnt = '0;
    endtask

    task automatic model_edge(input logic v, input logic [K-1:0] w, input logic r, input logic c);
        bit nv;
        if (m_valid && r) m_cnt = m_cnt + 1;
        nv = m_valid && !r;
        if (pend) begin
            if (nv) m_err = 1;
            else begin m_result = pend_val; nv = 1; end
        end
        m_valid = nv;
        if (c) m_err = 0;
        pend = 0;
        if (c) q.delete();
        else if (v) begin
            q.push_back(w);
            if (q.size() == N) begin
                for (int i = 0; i < N; i++) pend_val[i*K +: K] = q[i];
                q.delete();
                pend = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        int wi;
        chk("rsa_valid", {31'b0, bus.rsa_valid}, {31'b0, m_valid});
        chk("busy", {31'b0, bus.busy}, {31'b0, q.size() != 0});
        chk("err_overflow", {31'b0, bus.err_overflow}, {31'b0, m_err});
`ifdef ME_COLLECT_CNT_EN
        chk("result_cnt", bus.result_cnt, m_cnt);
`endif
        checks++;
        assert (bus.rsa_result === m_result) else begin
            errors++;
            wi = 0;
            for (int i = N - 1; i >= 0; i--)
                if (bus.rsa_result[i*K +: K] !== m_result[i*K +: K]) wi = i;
            $error("FAIL rsa_result word %0d observed=%h expected=%h", wi,
                   bus.rsa_result[wi*K +: K], m_result[wi*K +: K]);
        end
    endtask

    task automatic step(input logic v, input logic [K-1:0] w, input logic r, input logic c);
        bus.me_valid = v; bus.me_result = w; bus.rsa_ready = r; bus.clr = c;
        @(posedge clk);
        model_edge(v, w, r, c);
        #1 chk_all();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1 model_reset();
        chk_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [K-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [K-1:0] wa, wb;
        wa = {16{8'h11}};
        wb = {16{8'h22}};
        bus.me_valid = 0; bus.me_result = '0; bus.rsa_ready = 0; bus.clr = 0;
        async_reset();
        // basic back-to-back burst, word i = i
        for (int i = 0; i < N; i++) step(1, K'(i), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        // gappy random burst
        for (int i = 0; i < N; i++) begin
            step(1, rnd_word(), 1, 0);
            step(0, rnd_word(), 1, 0);
        end
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        // back-pressure with dropped second result, then clr
        for (int i = 0; i < N; i++) step(1, wa, 0, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < N; i++) step(1, wb, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        // take on the exact edge a new result lands
        for (int i = 0; i < N; i++) step(1, wa, 0, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < N; i++) step(1, wb, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        // abort after 7 words, clr together with a valid word, then a clean burst
        for (int i = 0; i < 7; i++) step(1, rnd_word(), 1, 0);
        step(1, rnd_word(), 1, 1);
        for (int i = 0; i < N; i++) step(1, rnd_word(), 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        // reset mid-burst while a result is held
        for (int i = 0; i < N; i++) step(1, rnd_word(), 0, 0);
        for (int i = 0; i < 5; i++) step(1, rnd_word(), 0, 0);
        async_reset();
        for (int i = 0; i < N; i++) step(1, rnd_word(), 1, 0);
        step(0, '0, 1, 0);
        // random traffic including wrap-around bursts, stalls and occasional clr
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 79) == 0);
        for (int n = 0; n < 4; n++) step(0, '0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/me_result_collector.md
Name: me_result_collector

Overview:
- Downstream stage of me_iddmm_top.
- Consumes the word-serial modular-exponentiation result: me_result (K bits) qualified by me_valid, N words, least-significant word first.
- Reassembles the words into one K*N-bit result and holds it for a wide consumer with a valid/ready handshake.
- Double-buffered, so a new result can stream in while the previous one waits to be taken.

Parameters:
- K, 128, word width in bits (matches me_iddmm_top word width).
- N, 16, words per result; K*N = 2048 for RSA2048.
- CNT_W, 5, word-counter width; must satisfy 2^CNT_W > N.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort: discards any partial collection and clears err_overflow; the held output is kept.
- me_result  input  K  result word from me_iddmm_top.
- me_valid  input  1  me_result is valid this cycle.
- rsa_result  output  K*N  assembled result; word 0 is in bits [K-1:0].
- rsa_valid  output  1  rsa_result holds an untaken result.
- rsa_ready  input  1  consumer accepts rsa_result.
- busy  output  1  collection in progress (word count nonzero).
- err_overflow  output  1  sticky; a completed result was dropped.

Behaviour:
- Reset: all outputs 0; shift buffer 0; word count 0; state IDLE.
- Input side has no back-pressure. Every cycle with me_valid=1 captures one word.
- Capture mechanism: shift buffer loads right, i.e. buf <= {me_result, buf[K*N-1:K]}. After N words, word 0 sits at the LSB.
- Gaps are allowed: me_valid low mid-burst holds both the count and the buffer.
- States:
  - IDLE: count = 0.
  - COLLECT: 0 < count < N.
  - IDLE → COLLECT on the first me_valid. COLLECT → IDLE on the capture of word N-1, with the count wrapping to 0.
- Completion (capture of word N-1):
  - Transfer {me_result, buf[K*N-1:K]} into the output register on the next edge.
  - rsa_valid rises on that same edge. Latency is 1 cycle from the last-word capture edge to rsa_valid.
- Output handshake: the result is taken on a clock edge with rsa_valid & rsa_ready. rsa_valid then drops on that edge unless a completion also occurs on it.
- rsa_result is stable while rsa_valid=1 and not taken. rsa_valid is not combinationally dependent on rsa_ready.
- Simultaneous completion and take (same edge): the new result is loaded, rsa_valid stays 1, and there is no overflow.
- Completion while rsa_valid=1 and not taken:
  - The new result is dropped and the output is unchanged.
  - err_overflow is set to 1 and held until clr or rst.
- busy = (count != 0).
- clr and me_valid in the same cycle: clr wins. The word is discarded and count becomes 0.
- clr does not affect rsa_valid or rsa_result.
- rst mid-burst: asynchronous clear of everything; the partial result is lost and no rsa_valid is produced.
- Words beyond N in one burst start a new collection (count wraps). No framing error is flagged.

Optional Feature:
- Macro: ME_COLLECT_CNT_EN.
- Defined:
  - Adds output port result_cnt [31:0], reset 0.
  - Increments by 1 on every result delivered to the consumer (rsa_valid & rsa_ready edge); wraps at 2^32.
  - Not cleared by clr.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package me_pkg holds:
  - K and N constants.
  - Derived width RSA_W = K*N.
  - State enum {IDLE, COLLECT}.
- One natural sub-module, me_word_deserializer: the shift buffer, word counter and completion pulse.
- The top keeps the output register, handshake and overflow logic.

Test Plan:
- Basic: after reset, stream 16 words 0x...00 through 0x...0F (word i = i) with back-to-back me_valid and rsa_ready=1.
  - rsa_valid pulses 1 cycle, 1 cycle after the last word.
  - rsa_result[127:0]=0, rsa_result[2047:1920]=15.
- Gappy input: big_x = 2048'hABA5E025…EAB744 sliced into 16 words, me_valid low on every other cycle.
  - rsa_result == big_x.
  - busy is high from the first word until the last.
- Back-pressure: rsa_ready=0 holding result A (all words 0x11…).
  - A second burst B (0x22…) completes → rsa_valid stays 1, rsa_result stays A, err_overflow=1.
  - clr → err_overflow=0.
- Simultaneous: rsa_ready pulsed on the exact edge where burst B completes while A is held.
  - A is taken, rsa_valid stays 1, rsa_result = B, err_overflow=0.
- Abort and reset:
  - After 7 words, assert clr → busy=0.
  - A following full burst yields the correct result with no stale words.
  - Repeat with rst asserted mid-burst → all outputs 0 immediately.
- ME_COLLECT_CNT_EN defined: 3 results taken → result_cnt=3; one dropped overflow result does not count.
